// File: rtl/prefetch_pc_gen_if.sv
// rtl/prefetch_pc_gen_if.sv - fetch-group handoff from preFetch to the ICache fetch stage
interface prefetch_pc_gen_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic        out_inst1_valid;
   logic        out_pred_taken;
   logic        out_pred_isinst1;
   logic [31:0] out_pred_target;

   modport master (
      output out_valid, out_pc, out_inst1_valid, out_pred_taken,
             out_pred_isinst1, out_pred_target,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_pc, out_inst1_valid, out_pred_taken,
             out_pred_isinst1, out_pred_target,
      output out_ready
   );
endinterface

// File: rtl/prefetch_pc_gen.sv
// rtl/prefetch_pc_gen.sv - fetch PC owner with delay-slot sequencing; PREFETCH_REDIRECT_BYPASS_EN removes the redirect bubble
module prefetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic               clk,
   input  logic               resetn,
   output logic [31:0]        PC0,
   output logic [31:0]        PC1,
   output logic               PC1_valid,
   output logic               predict_rden,
   input  logic               predict_jump,
   input  logic [31:0]        predict_jump_target,
   input  logic               predict_isinst1,
   input  logic               commit_redirect_en,
   input  logic [31:0]        commit_redirect_pc,
   input  logic               decode_redirect_en,
   input  logic [31:0]        decode_redirect_pc,
   prefetch_pc_gen_if.master  out_if
);

   typedef enum logic {RUN = 1'b0, DSLOT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_inst1_valid_q, out_inst1_valid_d;
   logic        out_pred_taken_q, out_pred_taken_d;
   logic        out_pred_isinst1_q, out_pred_isinst1_d;
   logic [31:0] out_pred_target_q, out_pred_target_d;

   logic        redir;
   logic [31:0] redir_pc;
   logic [31:0] look_pc;
   logic        look_run;
   logic        advance;
   logic        slot1_in;
   logic [31:0] seq;

   always_comb begin
      redir    = commit_redirect_en | decode_redirect_en;
      redir_pc = (commit_redirect_en ? commit_redirect_pc : decode_redirect_pc) & ~32'h3;
`ifdef PREFETCH_REDIRECT_BYPASS_EN
      // The redirect address is looked up directly; the flushed output slot counts as free.
      look_pc  = redir ? redir_pc : pc_q;
      look_run = redir | (state_q == RUN);
      advance  = redir | ~out_valid_q | out_if.out_ready;
`else
      look_pc  = pc_q;
      look_run = (state_q == RUN);
      advance  = (~out_valid_q | out_if.out_ready) & ~redir;
`endif
      slot1_in     = ~look_pc[2] & look_run;
      seq          = {look_pc[31:3] + 29'd1, 3'b000};
      PC0          = look_pc;
      PC1          = look_pc + 32'd4;
      PC1_valid    = slot1_in;
      predict_rden = advance & look_run & resetn;
   end

   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      tgt_d              = tgt_q;
      out_valid_d        = out_valid_q;
      out_pc_d           = out_pc_q;
      out_inst1_valid_d  = out_inst1_valid_q;
      out_pred_taken_d   = out_pred_taken_q;
      out_pred_isinst1_d = out_pred_isinst1_q;
      out_pred_target_d  = out_pred_target_q;

      if (advance) begin
         out_valid_d = 1'b1;
         out_pc_d    = look_pc;
         if (look_run) begin
            out_inst1_valid_d  = slot1_in;
            out_pred_taken_d   = predict_jump;
            out_pred_isinst1_d = predict_isinst1;
            out_pred_target_d  = predict_jump_target;
            state_d            = RUN;
            if (!predict_jump) begin
               pc_d = seq;
            end else if (!predict_isinst1 && slot1_in) begin
               pc_d = predict_jump_target & ~32'h3;
            end else begin
               // Delay slot lies outside this group: fetch it alone, then the target.
               tgt_d   = predict_jump_target & ~32'h3;
               pc_d    = seq;
               state_d = DSLOT;
            end
         end else begin
            out_inst1_valid_d  = 1'b0;
            out_pred_taken_d   = 1'b0;
            out_pred_isinst1_d = 1'b0;
            out_pred_target_d  = 32'h0;
            pc_d               = tgt_q;
            state_d            = RUN;
         end
      end else if (redir) begin
         pc_d        = redir_pc;
         state_d     = RUN;
         out_valid_d = 1'b0;
      end else if (out_if.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q            <= RUN;
         pc_q               <= RESET_PC & ~32'h3;
         tgt_q              <= 32'h0;
         out_valid_q        <= 1'b0;
         out_pc_q           <= 32'h0;
         out_inst1_valid_q  <= 1'b0;
         out_pred_taken_q   <= 1'b0;
         out_pred_isinst1_q <= 1'b0;
         out_pred_target_q  <= 32'h0;
      end else begin
         state_q            <= state_d;
         pc_q               <= pc_d;
         tgt_q              <= tgt_d;
         out_valid_q        <= out_valid_d;
         out_pc_q           <= out_pc_d;
         out_inst1_valid_q  <= out_inst1_valid_d;
         out_pred_taken_q   <= out_pred_taken_d;
         out_pred_isinst1_q <= out_pred_isinst1_d;
         out_pred_target_q  <= out_pred_target_d;
      end
   end

   assign out_if.out_valid        = out_valid_q;
   assign out_if.out_pc           = out_pc_q;
   assign out_if.out_inst1_valid  = out_inst1_valid_q;
   assign out_if.out_pred_taken   = out_pred_taken_q;
   assign out_if.out_pred_isinst1 = out_pred_isinst1_q;
   assign out_if.out_pred_target  = out_pred_target_q;

endmodule

// File: tb/tb_prefetch_pc_gen.sv
// tb/tb_prefetch_pc_gen.sv - directed vector bench for prefetch_pc_gen (default build, one-bubble redirect)
module tb_prefetch_pc_gen;

   logic        clk;
   logic        resetn;
   logic [31:0] PC0, PC1;
   logic        PC1_valid, predict_rden;
   logic        predict_jump, predict_isinst1;
   logic [31:0] predict_jump_target;
   logic        commit_redirect_en, decode_redirect_en;
   logic [31:0] commit_redirect_pc, decode_redirect_pc;

   prefetch_pc_gen_if out_if ();

   prefetch_pc_gen #(.RESET_PC(32'hBFC00000)) dut (
      .clk                 (clk),
      .resetn              (resetn),
      .PC0                 (PC0),
      .PC1                 (PC1),
      .PC1_valid           (PC1_valid),
      .predict_rden        (predict_rden),
      .predict_jump        (predict_jump),
      .predict_jump_target (predict_jump_target),
      .predict_isinst1     (predict_isinst1),
      .commit_redirect_en  (commit_redirect_en),
      .commit_redirect_pc  (commit_redirect_pc),
      .decode_redirect_en  (decode_redirect_en),
      .decode_redirect_pc  (decode_redirect_pc),
      .out_if              (out_if.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        cr;
      logic        dr;
      logic [31:0] rpc;
      logic        pj;
      logic        pj1;
      logic [31:0] ptgt;
      logic        rdy;
      logic [31:0] e_pc0;
      logic        e_rden;
      logic        e_ov;
      logic [31:0] e_opc;
      logic        e_oi1;
      logic        e_ot;
   } vec_t;

   vec_t tbl[18];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic cr, input logic dr, input logic [31:0] rpc,
                               input logic pj, input logic pj1, input logic [31:0] ptgt,
                               input logic rdy, input logic [31:0] e_pc0, input logic e_rden,
                               input logic e_ov, input logic [31:0] e_opc,
                               input logic e_oi1, input logic e_ot);
      vec_t v;
      v.cr = cr; v.dr = dr; v.rpc = rpc; v.pj = pj; v.pj1 = pj1; v.ptgt = ptgt;
      v.rdy = rdy; v.e_pc0 = e_pc0; v.e_rden = e_rden; v.e_ov = e_ov;
      v.e_opc = e_opc; v.e_oi1 = e_oi1; v.e_ot = e_ot;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      commit_redirect_en  = 1'b0;
      commit_redirect_pc  = 32'hDEAD0000;
      decode_redirect_en  = 1'b0;
      decode_redirect_pc  = 32'hDEAD0000;
      predict_jump        = 1'b0;
      predict_isinst1     = 1'b0;
      predict_jump_target = 32'h0;
      out_if.out_ready    = 1'b1;
   endtask

   initial begin
      // cr dr rpc | pj pj1 tgt | rdy | PC0 rden | ov out_pc oi1 ot
      tbl[0]  = mk(0,0,32'h0,        0,0,32'h0,        1, 32'hBFC00000,1, 1,32'hBFC00000,1,0);
      tbl[1]  = mk(0,0,32'h0,        0,0,32'h0,        1, 32'hBFC00008,1, 1,32'hBFC00008,1,0);
      tbl[2]  = mk(0,0,32'h0,        0,0,32'h0,        1, 32'hBFC00010,1, 1,32'hBFC00010,1,0);
      tbl[3]  = mk(1,0,32'h80000000, 0,0,32'h0,        1, 32'hBFC00018,0, 0,32'hBFC00010,1,0);
      tbl[4]  = mk(0,0,32'h0,        1,0,32'h80001000, 1, 32'h80000000,1, 1,32'h80000000,1,1);
      tbl[5]  = mk(0,0,32'h0,        1,1,32'h80002000, 1, 32'h80001000,1, 1,32'h80001000,1,1);
      tbl[6]  = mk(0,0,32'h0,        1,0,32'h99990000, 1, 32'h80001008,0, 1,32'h80001008,0,0);
      tbl[7]  = mk(0,0,32'h0,        0,0,32'h0,        1, 32'h80002000,1, 1,32'h80002000,1,0);
      tbl[8]  = mk(0,1,32'h80000006, 0,0,32'h0,        1, 32'h80002008,0, 0,32'h80002000,1,0);
      tbl[9]  = mk(0,0,32'h0,        0,0,32'h0,        1, 32'h80000004,1, 1,32'h80000004,0,0);
      tbl[10] = mk(0,0,32'h0,        1,0,32'h80003000, 1, 32'h80000008,1, 1,32'h80000008,1,1);
      tbl[11] = mk(1,0,32'h8000300C, 0,0,32'h0,        1, 32'h80003000,0, 0,32'h80000008,1,1);
      tbl[12] = mk(0,0,32'h0,        1,0,32'h80004000, 1, 32'h8000300C,1, 1,32'h8000300C,0,1);
      tbl[13] = mk(0,0,32'h0,        0,0,32'h0,        1, 32'h80003010,0, 1,32'h80003010,0,0);
      tbl[14] = mk(0,0,32'h0,        0,0,32'h0,        1, 32'h80004000,1, 1,32'h80004000,1,0);
      tbl[15] = mk(1,0,32'hFFFFFFF8, 0,0,32'h0,        1, 32'h80004008,0, 0,32'h80004000,1,0);
      tbl[16] = mk(0,0,32'h0,        0,0,32'h0,        1, 32'hFFFFFFF8,1, 1,32'hFFFFFFF8,1,0);
      tbl[17] = mk(0,0,32'h0,        0,0,32'h0,        1, 32'h00000000,1, 1,32'h00000000,1,0);

      idle_inputs();
      resetn = 1'b0;
      tick();
      #1;
      chk("reset_rden", {31'b0, predict_rden}, 32'd0);
      tick();
      chk("reset_ov",   {31'b0, out_if.out_valid}, 32'd0);
      chk("reset_opc",  out_if.out_pc, 32'h0);
      chk("reset_oi1",  {31'b0, out_if.out_inst1_valid}, 32'd0);
      chk("reset_ot",   {31'b0, out_if.out_pred_taken}, 32'd0);
      chk("reset_otgt", out_if.out_pred_target, 32'h0);
      chk("reset_pc0",  PC0, 32'hBFC00000);
      chk("reset_pc1",  PC1, 32'hBFC00004);
      resetn = 1'b1;

      for (int i = 0; i < 18; i++) begin
         commit_redirect_en  = tbl[i].cr;
         commit_redirect_pc  = tbl[i].cr ? tbl[i].rpc : 32'hDEAD0000;
         decode_redirect_en  = tbl[i].dr;
         decode_redirect_pc  = tbl[i].dr ? tbl[i].rpc : 32'hDEAD0000;
         predict_jump        = tbl[i].pj;
         predict_isinst1     = tbl[i].pj1;
         predict_jump_target = tbl[i].ptgt;
         out_if.out_ready    = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d_pc0", i),  PC0, tbl[i].e_pc0);
         chk($sformatf("v%0d_pc1", i),  PC1, tbl[i].e_pc0 + 32'd4);
         chk($sformatf("v%0d_rden", i), {31'b0, predict_rden}, {31'b0, tbl[i].e_rden});
         tick();
         chk($sformatf("v%0d_ov", i),  {31'b0, out_if.out_valid}, {31'b0, tbl[i].e_ov});
         chk($sformatf("v%0d_opc", i), out_if.out_pc, tbl[i].e_opc);
         chk($sformatf("v%0d_oi1", i), {31'b0, out_if.out_inst1_valid}, {31'b0, tbl[i].e_oi1});
         chk($sformatf("v%0d_ot", i),  {31'b0, out_if.out_pred_taken}, {31'b0, tbl[i].e_ot});
      end

      // Stall three cycles: pc=0x8, output holds group 0x0.
      idle_inputs();
      out_if.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d_pc0", k),  PC0, 32'h00000008);
         chk($sformatf("stall%0d_rden", k), {31'b0, predict_rden}, 32'd0);
         tick();
         chk($sformatf("stall%0d_ov", k),  {31'b0, out_if.out_valid}, 32'd1);
         chk($sformatf("stall%0d_opc", k), out_if.out_pc, 32'h00000000);
         chk($sformatf("stall%0d_oi1", k), {31'b0, out_if.out_inst1_valid}, 32'd1);
      end
      out_if.out_ready = 1'b1;
      #1;
      chk("unstall_rden", {31'b0, predict_rden}, 32'd1);
      tick();
      chk("unstall_opc", out_if.out_pc, 32'h00000008);

      // Enter DSLOT from pc=0x10, then collide Commit and Decode redirects.
      predict_jump = 1'b1; predict_isinst1 = 1'b1; predict_jump_target = 32'h12340000;
      tick();
      idle_inputs();
      #1;
      chk("dslot_pc0", PC0, 32'h00000018);
      chk("dslot_p1v", {31'b0, PC1_valid}, 32'd0);
      commit_redirect_en = 1'b1; commit_redirect_pc = 32'h80005000;
      decode_redirect_en = 1'b1; decode_redirect_pc = 32'h80006000;
      #1;
      chk("both_rden", {31'b0, predict_rden}, 32'd0);
      tick();
      idle_inputs();
      chk("both_ov", {31'b0, out_if.out_valid}, 32'd0);
      #1;
      chk("both_pc0", PC0, 32'h80005000);
      chk("both_p1v", {31'b0, PC1_valid}, 32'd1);
      chk("both_rden2", {31'b0, predict_rden}, 32'd1);
      tick();
      chk("both_opc", out_if.out_pc, 32'h80005000);
      chk("both_next_pc0", PC0, 32'h80005008);
      tick();
      chk("both_after_pc0", PC0, 32'h80005010);

      // Reset while in DSLOT drops the saved target.
      predict_jump = 1'b1; predict_isinst1 = 1'b1; predict_jump_target = 32'h55550000;
      tick();
      idle_inputs();
      chk("rdslot_pc0", PC0, 32'h80005018);
      resetn = 1'b0;
      #1;
      chk("rdslot_rden", {31'b0, predict_rden}, 32'd0);
      tick();
      chk("rdslot_ov",  {31'b0, out_if.out_valid}, 32'd0);
      chk("rdslot_opc", out_if.out_pc, 32'h0);
      chk("rdslot_pc0", PC0, 32'hBFC00000);
      chk("rdslot_p1v", {31'b0, PC1_valid}, 32'd1);
      resetn = 1'b1;
      tick();
      chk("rdslot_first", out_if.out_pc, 32'hBFC00000);
      chk("rdslot_next",  PC0, 32'hBFC00008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prefetch_pc_gen.md
# prefetch_pc_gen

Front-end preFetch stage that owns the fetch PC. It drives the two-slot lookup port of the branch predictor and turns the prediction into the next fetch group, including MIPS delay-slot sequencing. It accepts redirects from Commit and Decode and hands each fetch group to the ICache fetch stage through a one-entry valid/ready output register.

## Interface
Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset (word aligned).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- PC0  out  32  slot-0 lookup address to predictor.
- PC1  out  32  slot-1 lookup address, always PC0+4.
- PC1_valid  out  1  slot 1 is in the group.
- predict_rden  out  1  group is consumed this cycle (lets the predictor pop its RAS).
- predict_jump  in  1  predictor says a branch in the group is taken.
- predict_jump_target  in  32  predicted target.
- predict_isinst1  in  1  taken branch is in slot 1.
- commit_redirect_en  in  1  Commit redirect (mispredict or exception), highest priority.
- commit_redirect_pc  in  32  Commit redirect address.
- decode_redirect_en  in  1  Decode redirect, lower priority.
- decode_redirect_pc  in  32  Decode redirect address.
- out_valid  out  1  fetch group is valid.
- out_ready  in  1  fetch stage accepts the group.
- out_pc  out  32  group base PC (slot 0).
- out_inst1_valid  out  1  slot 1 is in the group.
- out_pred_taken  out  1  group carries a taken prediction.
- out_pred_isinst1  out  1  the taken branch is in slot 1.
- out_pred_target  out  32  predicted target.

## Operation
- Registers:
  - pc: current group address. Bits [1:0] are forced to 0 on every load.
  - state: RUN or DSLOT.
  - tgt: saved target, 32 bits.
  - Output register: all out_* signals.
- Lookup drives (combinational):
  - PC0 = pc.
  - PC1 = pc+4.
  - PC1_valid = ~pc[2] & (state==RUN).
- advance = (~out_valid | out_ready) & ~commit_redirect_en & ~decode_redirect_en.
- predict_rden = advance & (state==RUN). It is 0 in DSLOT, so the RAS is never popped for the delay-slot group.
- seq = {pc[31:3]+1, 3'b000}. The 29-bit increment wraps modulo 2^32.
- RUN, on advance:
  - Capture the group: out_pc=pc, out_inst1_valid=PC1_valid, and the prediction fields.
  - Not taken: pc<=seq.
  - Taken, slot 0, with PC1_valid=1: the delay slot is already in the group, so pc<=predict_jump_target.
  - Taken with predict_isinst1=1, or taken with PC1_valid=0: tgt<=predict_jump_target, pc<=seq, state<=DSLOT.
- DSLOT, on advance:
  - Capture a single-instruction group at pc with out_inst1_valid=0 and out_pred_taken=0.
  - Then pc<=tgt, state<=RUN.
- Output register:
  - Loads on advance.
  - Clears out_valid when out_ready=1 and there is no advance.
  - Holds all fields while out_valid & ~out_ready.
- Redirect:
  - Commit and Decode redirects are handled identically, except that Commit wins when both are asserted.
  - Effect: pc<=redirect_pc, state<=RUN, out_valid<=0 (the younger group is flushed even if out_ready=1), no capture, predict_rden=0.
- Reset, next edge while resetn=0:
  - pc=RESET_PC, state=RUN, tgt=0.
  - out_valid=0, out_pc=0, out_inst1_valid=0, out_pred_taken=0, out_pred_isinst1=0, out_pred_target=0.
  - predict_rden=0 while in reset.
  - A reset asserted during DSLOT abandons the saved target.

## Timing
- A lookup in cycle N appears on out_* in cycle N+1, so the stage latency is 1 cycle.
- Sustained throughput is one group per cycle while out_ready=1.
- Redirect in cycle N: the first group from the new PC is looked up in N+1 and output in N+2, giving one bubble.
- A taken prediction with the delay slot outside the group costs exactly one extra single-instruction group. There is no bubble.
- Stall: pc, state and tgt are frozen while out_valid & ~out_ready. The same PC0/PC1 are re-presented, and predict_rden stays 0.

## Configuration
- PREFETCH_REDIRECT_BYPASS_EN defined:
  - In a redirect cycle, PC0 is driven with redirect_pc (Commit wins), bits [1:0] zeroed.
  - The group is captured and the next PC computed in the same cycle, treated as RUN, with predict_rden=1.
  - First new group appears on out_* in N+1, so there is no bubble.
  - The output slot counts as free in that cycle, since its old content is flushed.
- Not defined: redirect behaviour is exactly as in Timing, with one bubble.

## Test plan
- Reset, never taken, out_ready=1 -> out_pc runs 0xBFC00000, 0xBFC00008, 0xBFC00010 with out_inst1_valid=1 and predict_rden=1 on every cycle.
- pc=0x80000000, taken slot 0, target 0x80001000 -> next out_pc=0x80001000, with no DSLOT group.
- pc=0x80000000, taken slot 1, target 0x80002000 -> out_pc=0x80000008 with out_inst1_valid=0, out_pred_taken=0 and predict_rden=0, then out_pc=0x80002000.
- Redirect to 0x80000006 -> out_pc=0x80000004 with out_inst1_valid=0 after one bubble. With PREFETCH_REDIRECT_BYPASS_EN there is no bubble.
- out_ready=0 for 3 cycles -> all out_* fields hold, predict_rden=0, and pc is unchanged.
- Commit and Decode redirect in the same cycle while in DSLOT -> Commit address wins, out_valid=0 next cycle, state=RUN, and the saved target is never fetched.
